chimera_memisland_init_ctrl: RTL and testbench
==============================================

Name: chimera_memisland_init_ctrl

Overview:
- Sequencer in front of the memory-island narrow AXI slave port, between the narrow crossbar and the atomics filter.
- After reset, or on command, it takes the narrow port, writes the island's full address range with a fill pattern using INCR bursts, then hands the port back.
- Outside init it is a pure passthrough.
- Gives software and clusters a deterministic memory state and sequences clean ownership hand-over of the island port.

Parameters:
- AddrWidth, 48, AXI address width
- DataWidth, 64, narrow AXI data width
- IdWidth, 4, AXI ID width; init ID is all-ones
- BaseAddr, 'h4800_0000, island base; aligned to BurstBytes
- MemSizeBytes, 'h10000, island size; multiple of DataWidth/8
- BurstLen, 16, beats per init burst (1..256); BurstBytes = BurstLen*DataWidth/8 ≤ 4096
- MaxOutstanding, 8, external transaction-count capacity per direction
- AutoInit, 1, start init automatically on first cycle out of reset
- axi_req_t, logic, narrow request struct
- axi_rsp_t, logic, narrow response struct

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- init_i  in  1  start pulse; honoured only in IDLE or DONE
- pattern_i  in  DataWidth  fill data, sampled at init start
- busy_o  out  1  high from start accept until DONE
- done_o  out  1  high in DONE
- slv_req_i  in  axi_req_t  external request
- slv_rsp_o  out  axi_rsp_t  external response
- mst_req_o  out  axi_req_t  toward atomics filter and island
- mst_rsp_i  in  axi_rsp_t  from island

Behaviour:
- One clock (clk_i). Reset is synchronous, active-low on rst_ni. All state clears on the sampled low; no asynchronous path.
- Reset values:
  - state = IDLE; busy_o = 0; done_o = 0; counters = 0
  - mst_req_o all valids 0
  - slv_rsp_o all readys and valids 0
- FSM states: IDLE, DRAIN, AW, W, B, DONE.
- Passthrough in IDLE and DONE:
  - mst_req_o = slv_req_i and slv_rsp_o = mst_rsp_i, combinational, zero latency.
  - Outstanding counters are 0..MaxOutstanding, saturating, with an assertion on overflow.
  - wr_cnt increments on AW handshake and decrements on B handshake; if both occur in the same cycle it is unchanged.
  - rd_cnt increments on AR handshake and decrements on R handshake with last.
- Start condition: AutoInit on the first post-reset cycle, or init_i in IDLE/DONE.
  - On start: latch pattern_i; clear addr_q (offset) and beat_q; assert busy_o next cycle; go to DRAIN.
  - done_o deasserts on leaving DONE.
- DRAIN:
  - External aw_ready and ar_ready forced 0. W, B and R channels still pass through.
  - Move to AW when wr_cnt = 0 and rd_cnt = 0 and no external W beat is pending. A W beat is pending when an AW was accepted but its last W beat has not yet been accepted (tracked with a 1-bit pending flag plus a count).
- AW, W, B (all external channels blocked: every ready and valid to slv is 0):
  - AW: aw_valid = 1.
    - Fields: addr = BaseAddr + addr_q; len = BurstLen-1; size = log2(DataWidth/8); burst = INCR; id = all-ones; other fields 0.
    - aw_valid holds stable until ready.
  - W: w_valid = 1, data = pattern, strb = all-ones, last when beat_q = BurstLen-1. beat_q increments on each handshake.
  - B: b_ready = 1.
    - On handshake: addr_q += BurstBytes. If addr_q + BurstBytes ≥ MemSizeBytes, go to DONE; else go to AW.
    - If MemSizeBytes is not a multiple of BurstBytes, the final burst len is (remaining bytes / (DataWidth/8)) - 1.
- Responses during init: non-OKAY B responses are ignored in the base build and init continues.
- init_i while busy is ignored.
- Reset mid-burst aborts immediately. The island side is reset together with this block, so no orphan beats remain.
- Elaboration assertions:
  - BaseAddr aligned to BurstBytes
  - MemSizeBytes a multiple of DataWidth/8
  - BurstBytes ≤ 4096

Optional Feature:
- Macro: CHIMERA_MEMISL_INIT_ERRCNT_EN.
- Defined: adds output err_cnt_o (16 bits, saturating). It counts B responses other than OKAY during init, clears on start accept, reset value 0.
- Undefined: port absent; error responses are ignored.

Decomposition:
- chimera_pkg gains:
  - init_state_e enum
  - MemIslInitBurstLen constant
  - MemIslInitId constant
- One sub-module: chimera_memisland_txn_tracker. It holds the wr/rd outstanding counters and the W-pending flag, and outputs a single idle flag used by DRAIN.
- chimera_memisland_domain instantiates the controller in front of i_memory_island_atomics.

Test Plan:
- Reset with AutoInit=1, MemSizeBytes='h1000, BurstLen=16, DataWidth=64 -> 32 bursts at addr 'h4800_0000, step 'h80; done_o after last B; readback of every word = pattern.
- External 4-beat write in flight (AW accepted, 2 W beats sent) when init_i pulses -> stays in DRAIN until external B returns; init AW issued only afterwards; external AR during DRAIN gets ar_ready=0.
- MemSizeBytes='h1040 -> final burst has len=7 at addr 'h4800_1000; then DONE.
- In DONE, external read of 'h4800_0008 -> passthrough with zero added latency; returns pattern 'hDEAD_BEEF_0000_0001.
- rst_ni low at beat 5 of burst 3 -> next cycle all mst valids 0, busy_o=0, state IDLE; with AutoInit=1, init restarts at offset 0.
- With CHIMERA_MEMISL_INIT_ERRCNT_EN, SLVERR injected on 3 B responses -> err_cnt_o = 3; init still completes.

Source files
------------

// File: rtl/chimera_memisland_init_ctrl_pkg.sv
// Shared types and constants for the memory-island init controller.
// Holds the narrow AXI request/response structs, the init FSM state
// enum and the init burst/ID constants used by the top and the tracker.
package chimera_memisland_init_ctrl_pkg;

  localparam int unsigned NarrowAddrWidth = 48;
  localparam int unsigned NarrowDataWidth = 64;
  localparam int unsigned NarrowIdWidth   = 4;

  localparam int unsigned MemIslInitBurstLen = 16;
  localparam logic [NarrowIdWidth-1:0] MemIslInitId = '1;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

  typedef enum logic [2:0] {
    IDLE, DRAIN, AW, W, B, DONE
  } init_state_e;

  typedef struct packed {
    logic [NarrowIdWidth-1:0]   id;
    logic [NarrowAddrWidth-1:0] addr;
    logic [7:0]                 len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
    logic [3:0]                 cache;
    logic [2:0]                 prot;
  } narrow_ax_t;

  typedef struct packed {
    logic [NarrowDataWidth-1:0]   data;
    logic [NarrowDataWidth/8-1:0] strb;
    logic                         last;
  } narrow_w_t;

  typedef struct packed {
    logic [NarrowIdWidth-1:0] id;
    logic [1:0]               resp;
  } narrow_b_t;

  typedef struct packed {
    logic [NarrowIdWidth-1:0]   id;
    logic [NarrowDataWidth-1:0] data;
    logic [1:0]                 resp;
    logic                       last;
  } narrow_r_t;

  typedef struct packed {
    narrow_ax_t aw;
    logic       aw_valid;
    narrow_w_t  w;
    logic       w_valid;
    logic       b_ready;
    narrow_ax_t ar;
    logic       ar_valid;
    logic       r_ready;
  } narrow_req_t;

  typedef struct packed {
    logic      aw_ready;
    logic      ar_ready;
    logic      w_ready;
    logic      b_valid;
    narrow_b_t b;
    logic      r_valid;
    narrow_r_t r;
  } narrow_rsp_t;

endpackage

// File: rtl/chimera_memisland_txn_tracker.sv
// Outstanding-transaction tracker for the external side of the island port.
// Counts accepted-but-unanswered writes and reads, plus AWs whose last W
// beat has not been accepted yet. idle_o is high only when nothing is open,
// which is what lets the controller take the port over cleanly.
// Ports: clk_i/rst_ni (sync, active low); *_hs_i handshake pulses seen on
// the external port; idle_o all counters zero and no W beat pending.
module chimera_memisland_txn_tracker #(
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic aw_hs_i,
  input  logic w_last_hs_i,
  input  logic b_hs_i,
  input  logic ar_hs_i,
  input  logic r_last_hs_i,
  output logic idle_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] wr_cnt_q, rd_cnt_q, wpend_cnt_q;
  logic [CntW-1:0] wpend_cnt_d;
  logic            wpend_q;

  // Saturating up/down; simultaneous inc and dec cancel.
  function automatic logic [CntW-1:0] upd(input logic [CntW-1:0] c,
                                          input logic inc, input logic dec);
    if (inc && !dec && c != CntMax) return c + 1'b1;
    if (dec && !inc && c != '0)     return c - 1'b1;
    return c;
  endfunction

  assign wpend_cnt_d = upd(wpend_cnt_q, aw_hs_i, w_last_hs_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wpend_cnt_q <= '0;
      wpend_q     <= 1'b0;
    end else begin
      wr_cnt_q    <= upd(wr_cnt_q, aw_hs_i, b_hs_i);
      rd_cnt_q    <= upd(rd_cnt_q, ar_hs_i, r_last_hs_i);
      wpend_cnt_q <= wpend_cnt_d;
      wpend_q     <= (wpend_cnt_d != '0);
    end
  end

  assign idle_o = (wr_cnt_q == '0) && (rd_cnt_q == '0) && !wpend_q;

  wr_cnt_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(aw_hs_i && !b_hs_i && wr_cnt_q == CntMax));
  rd_cnt_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ar_hs_i && !r_last_hs_i && rd_cnt_q == CntMax));

endmodule

// File: rtl/chimera_memisland_init_ctrl.sv
// Memory-island init sequencer on the narrow AXI port. After reset (AutoInit)
// or on init_i it drains external traffic, fills the whole island with a
// pattern using INCR bursts, then returns the port. Passthrough otherwise.
// Ports: clk_i/rst_ni (sync, active low); init_i start pulse (IDLE/DONE only);
// pattern_i fill data sampled at start; busy_o init in progress; done_o in
// DONE; slv_req_i/slv_rsp_o external side; mst_req_o/mst_rsp_i island side;
// err_cnt_o non-OKAY B count during init (only with CHIMERA_MEMISL_INIT_ERRCNT_EN).
module chimera_memisland_init_ctrl
  import chimera_memisland_init_ctrl_pkg::*;
#(
  parameter int unsigned          AddrWidth      = NarrowAddrWidth,
  parameter int unsigned          DataWidth      = NarrowDataWidth,
  parameter int unsigned          IdWidth        = NarrowIdWidth,
  parameter logic [AddrWidth-1:0] BaseAddr       = 'h4800_0000,
  parameter int unsigned          MemSizeBytes   = 'h10000,
  parameter int unsigned          BurstLen       = MemIslInitBurstLen,
  parameter int unsigned          MaxOutstanding = 8,
  parameter bit                   AutoInit       = 1'b1,
  parameter type                  axi_req_t      = narrow_req_t,
  parameter type                  axi_rsp_t      = narrow_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_i,
  input  logic [DataWidth-1:0] pattern_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  axi_req_t             slv_req_i,
  output axi_rsp_t             slv_rsp_o,
  output axi_req_t             mst_req_o,
  input  axi_rsp_t             mst_rsp_i
`ifdef CHIMERA_MEMISL_INIT_ERRCNT_EN
  ,
  output logic [15:0]          err_cnt_o
`endif
);

  localparam int unsigned BeatBytes  = DataWidth / 8;
  localparam int unsigned BeatShift  = $clog2(BeatBytes);
  localparam int unsigned BurstBytes = BurstLen * BeatBytes;
  localparam logic [2:0]  AxSize     = 3'(BeatShift);
  localparam logic [AddrWidth-1:0] MemSize   = AddrWidth'(MemSizeBytes);
  localparam logic [AddrWidth-1:0] BurstStep = AddrWidth'(BurstBytes);

  if ((BaseAddr % BurstStep) != '0) begin : g_chk_align
    $error("BaseAddr must be aligned to the init burst size");
  end
  if ((MemSizeBytes % BeatBytes) != 0) begin : g_chk_size
    $error("MemSizeBytes must be a multiple of the beat size");
  end
  if (BurstBytes > 4096 || BurstLen < 1 || BurstLen > 256) begin : g_chk_burst
    $error("init burst must be 1..256 beats and stay within 4 KiB");
  end
  if (IdWidth < 1) begin : g_chk_id
    $error("IdWidth must be at least 1");
  end

  init_state_e            state_q, state_d;
  logic                   first_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [7:0]             beat_q;
  logic [DataWidth-1:0]   pattern_q;
  logic                   start, trk_idle;
  logic [AddrWidth-1:0]   rem_bytes, rem_beats;
  logic [7:0]             cur_len;
  logic                   last_beat, last_burst, w_hs, b_hs;

  // Final burst shrinks when the island is not a whole number of bursts.
  assign rem_bytes  = MemSize - addr_q;
  assign rem_beats  = rem_bytes >> BeatShift;
  assign cur_len    = (rem_bytes >= BurstStep) ? 8'(BurstLen - 1) : 8'(rem_beats - 1'b1);
  assign last_beat  = (beat_q == cur_len);
  assign last_burst = (addr_q + BurstStep) >= MemSize;
  assign w_hs       = (state_q == W) && mst_rsp_i.w_ready;
  assign b_hs       = (state_q == B) && mst_rsp_i.b_valid;

  chimera_memisland_txn_tracker #(
    .MaxOutstanding(MaxOutstanding)
  ) i_txn_tracker (
    .clk_i,
    .rst_ni,
    .aw_hs_i     (slv_req_i.aw_valid & slv_rsp_o.aw_ready),
    .w_last_hs_i (slv_req_i.w_valid & slv_rsp_o.w_ready & slv_req_i.w.last),
    .b_hs_i      (slv_rsp_o.b_valid & slv_req_i.b_ready),
    .ar_hs_i     (slv_req_i.ar_valid & slv_rsp_o.ar_ready),
    .r_last_hs_i (slv_rsp_o.r_valid & slv_req_i.r_ready & slv_rsp_o.r.last),
    .idle_o      (trk_idle)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      first_q   <= AutoInit;
      addr_q    <= '0;
      beat_q    <= '0;
      pattern_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      if (start) begin
        pattern_q <= pattern_i;
        addr_q    <= '0;
        beat_q    <= '0;
      end else begin
        if (w_hs) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
        if (b_hs) addr_q <= addr_q + BurstStep;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    mst_req_o = '0;
    slv_rsp_o = '0;
    unique case (state_q)
      IDLE, DONE: begin
        mst_req_o = slv_req_i;
        slv_rsp_o = mst_rsp_i;
        if ((state_q == IDLE && first_q) || init_i) begin
          start   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // New AW/AR are held off; open transactions finish through W/B/R.
        mst_req_o          = slv_req_i;
        slv_rsp_o          = mst_rsp_i;
        mst_req_o.aw_valid = 1'b0;
        mst_req_o.ar_valid = 1'b0;
        slv_rsp_o.aw_ready = 1'b0;
        slv_rsp_o.ar_ready = 1'b0;
        if (trk_idle) state_d = AW;
      end
      AW: begin
        mst_req_o.aw_valid = 1'b1;
        mst_req_o.aw.addr  = BaseAddr + addr_q;
        mst_req_o.aw.len   = cur_len;
        mst_req_o.aw.size  = AxSize;
        mst_req_o.aw.burst = AxiBurstIncr;
        mst_req_o.aw.id    = MemIslInitId;
        if (mst_rsp_i.aw_ready) state_d = W;
      end
      W: begin
        mst_req_o.w_valid = 1'b1;
        mst_req_o.w.data  = pattern_q;
        mst_req_o.w.strb  = '1;
        mst_req_o.w.last  = last_beat;
        if (mst_rsp_i.w_ready && last_beat) state_d = B;
      end
      B: begin
        mst_req_o.b_ready = 1'b1;
        if (mst_rsp_i.b_valid) state_d = last_burst ? DONE : AW;
      end
      default: state_d = IDLE;
    endcase
    // Nothing leaves the block while reset is sampled low.
    if (!rst_ni) begin
      mst_req_o = '0;
      slv_rsp_o = '0;
    end
  end

  assign busy_o = (state_q == DRAIN) || (state_q == AW) || (state_q == W) || (state_q == B);
  assign done_o = (state_q == DONE);

`ifdef CHIMERA_MEMISL_INIT_ERRCNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)    err_cnt_q <= '0;
    else if (start) err_cnt_q <= '0;
    else if (b_hs && mst_rsp_i.b.resp != AxiRespOkay && err_cnt_q != 16'hFFFF)
      err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_chimera_memisland_init_ctrl.sv
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))
module tb_chimera_memisland_init_ctrl;
  import chimera_memisland_init_ctrl_pkg::*;

  localparam logic [47:0] BASE   = 48'h4800_0000;
  localparam int unsigned MEMB   = 'h1040;
  localparam int          NWORDS = MEMB / 8;

  logic        clk = 1'b0, rst_n = 1'b0, init = 1'b0;
  logic [63:0] pattern = '0;
  logic        busy, done;
  narrow_req_t slv_req = '0, mst_req;
  narrow_rsp_t slv_rsp, mst_rsp;
`ifdef CHIMERA_MEMISL_INIT_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  chimera_memisland_init_ctrl #(
    .BaseAddr(BASE), .MemSizeBytes(MEMB), .BurstLen(16), .AutoInit(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .init_i(init), .pattern_i(pattern),
    .busy_o(busy), .done_o(done),
    .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
    .mst_req_o(mst_req), .mst_rsp_i(mst_rsp)
`ifdef CHIMERA_MEMISL_INIT_ERRCNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  // ---------------- island memory model ----------------
  logic [63:0] mem [0:NWORDS-1];
  logic [47:0] aw_log_addr [0:255];
  logic [7:0]  aw_log_len  [0:255];
  logic [3:0]  aw_log_id   [0:255];
  logic [2:0]  aw_log_size [0:255];
  int          aw_n = 0, w_n = 0, err_given = 0;
  logic        inj_en = 1'b0;
  logic        m_wact = 1'b0, m_bpend = 1'b0, m_ract = 1'b0;
  logic [47:0] m_waddr = '0, m_raddr = '0;
  logic [7:0]  m_rlen = '0;
  logic [3:0]  m_bid = '0, m_rid = '0;
  logic [1:0]  m_bresp = '0;

  function automatic int widx(input logic [47:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  always_comb begin
    int ri;
    ri = widx(m_raddr);
    mst_rsp          = '0;
    mst_rsp.aw_ready = !m_wact && !m_bpend;
    mst_rsp.w_ready  = m_wact;
    mst_rsp.b_valid  = m_bpend;
    mst_rsp.b.id     = m_bid;
    mst_rsp.b.resp   = m_bresp;
    mst_rsp.ar_ready = !m_ract;
    mst_rsp.r_valid  = m_ract;
    mst_rsp.r.id     = m_rid;
    mst_rsp.r.last   = (m_rlen == 8'd0);
    mst_rsp.r.data   = (ri >= 0 && ri < NWORDS) ? mem[ri] : 64'd0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_wact <= 1'b0; m_bpend <= 1'b0; m_ract <= 1'b0;
    end else begin
      if (mst_req.aw_valid && mst_rsp.aw_ready) begin
        m_wact <= 1'b1; m_waddr <= mst_req.aw.addr; m_bid <= mst_req.aw.id;
        aw_log_addr[aw_n[7:0]] <= mst_req.aw.addr;
        aw_log_len[aw_n[7:0]]  <= mst_req.aw.len;
        aw_log_id[aw_n[7:0]]   <= mst_req.aw.id;
        aw_log_size[aw_n[7:0]] <= mst_req.aw.size;
        aw_n <= aw_n + 1;
      end
      if (mst_req.w_valid && mst_rsp.w_ready) begin
        if (widx(m_waddr) >= 0 && widx(m_waddr) < NWORDS) mem[widx(m_waddr)] <= mst_req.w.data;
        m_waddr <= m_waddr + 48'd8;
        w_n <= w_n + 1;
        if (mst_req.w.last) begin
          m_wact <= 1'b0; m_bpend <= 1'b1;
          m_bresp <= (inj_en && err_given < 3) ? 2'b10 : 2'b00;
          if (inj_en && err_given < 3) err_given <= err_given + 1;
        end
      end
      if (mst_rsp.b_valid && mst_req.b_ready) m_bpend <= 1'b0;
      if (mst_req.ar_valid && mst_rsp.ar_ready) begin
        m_ract <= 1'b1; m_raddr <= mst_req.ar.addr; m_rlen <= mst_req.ar.len; m_rid <= mst_req.ar.id;
      end
      if (mst_rsp.r_valid && mst_req.r_ready) begin
        if (m_rlen == 8'd0) m_ract <= 1'b0;
        else begin m_raddr <= m_raddr + 48'd8; m_rlen <= m_rlen - 8'd1; end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    `CHK(tag, done, 1'b1);
  endtask

  task automatic chk_mem(input string tag, input logic [63:0] p);
    int bad = 0;
    for (int i = 0; i < NWORDS; i++) if (mem[i] !== p) bad++;
    `CHK(tag, bad, 0);
  endtask

  task automatic ext_w(input logic [63:0] d, input logic l);
    int n = 0;
    slv_req.w_valid = 1'b1; slv_req.w.data = d; slv_req.w.strb = '1; slv_req.w.last = l;
    #1;
    while (!slv_rsp.w_ready && n < 50) begin tick(); n++; end
    if (n >= 50) `CHK("ext_w_timeout", 1'b0, 1'b1);
    tick();
    slv_req.w_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [63:0] rdata;
  int          n, aw0, wn0, aw1;
  logic        seen_aw, seen_arr, seen_arv;

  initial begin
    // reset: external valids must not reach the island, readys not the master
    pattern = 64'hDEAD_BEEF_0000_0001;
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    tick(3);
    `CHK("rst_mst_ar_valid", mst_req.ar_valid, 1'b0);
    `CHK("rst_mst_aw_valid", mst_req.aw_valid, 1'b0);
    `CHK("rst_slv_ar_ready", slv_rsp.ar_ready, 1'b0);
    `CHK("rst_slv_aw_ready", slv_rsp.aw_ready, 1'b0);
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_done", done, 1'b0);
    slv_req = '0;
    rst_n = 1'b1;
    tick();
    `CHK("auto_busy", busy, 1'b1);

    // AutoInit fill: 32 full bursts step 'h80, then a len=7 tail at 'h1000
    wait_done("init1_done");
    `CHK("init1_busy_low", busy, 1'b0);
    `CHK("init1_aw_count", aw_n, 33);
    `CHK("init1_aw0_addr", aw_log_addr[0], BASE);
    `CHK("init1_aw1_addr", aw_log_addr[1], BASE + 48'h80);
    `CHK("init1_aw31_addr", aw_log_addr[31], BASE + 48'hF80);
    `CHK("init1_aw31_len", aw_log_len[31], 8'd15);
    `CHK("init1_aw32_addr", aw_log_addr[32], BASE + 48'h1000);
    `CHK("init1_aw32_len", aw_log_len[32], 8'd7);
    `CHK("init1_aw_id", aw_log_id[0], 4'hF);
    `CHK("init1_aw_size", aw_log_size[0], 3'd3);
    `CHK("init1_beats", w_n, 520);
    chk_mem("init1_mem", 64'hDEAD_BEEF_0000_0001);

    // DONE: passthrough read, zero added latency
    slv_req.ar = '0; slv_req.ar.addr = BASE + 48'h8; slv_req.ar.size = 3'd3;
    slv_req.ar.burst = AxiBurstIncr; slv_req.ar_valid = 1'b1; slv_req.r_ready = 1'b1;
    #1;
    `CHK("done_ar_pass_valid", mst_req.ar_valid, 1'b1);
    `CHK("done_ar_pass_addr", mst_req.ar.addr, BASE + 48'h8);
    `CHK("done_ar_ready", slv_rsp.ar_ready, 1'b1);
    tick();
    slv_req.ar_valid = 1'b0;
    `CHK("done_r_valid", slv_rsp.r_valid, 1'b1);
    rdata = slv_rsp.r.data;
    `CHK("done_r_data", rdata, 64'hDEAD_BEEF_0000_0001);
    tick();
    slv_req.r_ready = 1'b0;

    // external 4-beat write in flight when init is requested
    pattern = 64'h1234_5678_9ABC_DEF0;
    slv_req.aw = '0; slv_req.aw.addr = BASE + 48'h100; slv_req.aw.len = 8'd3;
    slv_req.aw.size = 3'd3; slv_req.aw.burst = AxiBurstIncr; slv_req.aw.id = 4'h2;
    slv_req.aw_valid = 1'b1;
    n = 0;
    #1;
    while (!slv_rsp.aw_ready && n < 50) begin tick(); n++; end
    tick();
    slv_req.aw_valid = 1'b0;
    ext_w(64'h11, 1'b0);
    ext_w(64'h22, 1'b0);
    init = 1'b1;
    tick();
    init = 1'b0;
    `CHK("drain_busy", busy, 1'b1);
    `CHK("drain_done_low", done, 1'b0);
    slv_req.ar = '0; slv_req.ar.addr = BASE; slv_req.ar_valid = 1'b1;
    seen_aw = 1'b0; seen_arr = 1'b0; seen_arv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      seen_aw  |= mst_req.aw_valid;
      seen_arr |= slv_rsp.ar_ready;
      seen_arv |= mst_req.ar_valid;
      tick();
    end
    `CHK("drain_no_init_aw", seen_aw, 1'b0);
    `CHK("drain_ar_ready", seen_arr, 1'b0);
    `CHK("drain_ar_blocked", seen_arv, 1'b0);
    slv_req.ar_valid = 1'b0;
    ext_w(64'h33, 1'b0);
    ext_w(64'h44, 1'b1);
    seen_aw = 1'b0;
    for (int i = 0; i < 8; i++) begin #1; seen_aw |= mst_req.aw_valid; tick(); end
    `CHK("drain_wait_b_no_aw", seen_aw, 1'b0);
    `CHK("drain_ext_b_valid", slv_rsp.b_valid, 1'b1);
    `CHK("drain_ext_b_id", slv_rsp.b.id, 4'h2);
    aw0 = aw_n;
    slv_req.b_ready = 1'b1;
    tick();
    slv_req.b_ready = 1'b0;
    wait_done("init2_done");
    `CHK("init2_aw_count", aw_n - aw0, 33);
    `CHK("init2_first_addr", aw_log_addr[aw0[7:0]], BASE);
    chk_mem("init2_mem", 64'h1234_5678_9ABC_DEF0);

    // reset at beat 5 of burst 3, then AutoInit restarts from offset 0
    pattern = 64'hA5A5_0000_FFFF_0003;
    aw0 = aw_n; wn0 = w_n;
    init = 1'b1;
    tick();
    init = 1'b0;
    n = 0;
    while ((w_n - wn0) < 37 && n < 2000) begin tick(); n++; end
    `CHK("midrst_beats", w_n - wn0, 37);
    `CHK("midrst_bursts", aw_n - aw0, 3);
    rst_n = 1'b0;
    #1;
    `CHK("midrst_w_valid", mst_req.w_valid, 1'b0);
    tick();
    `CHK("midrst_busy", busy, 1'b0);
    `CHK("midrst_done", done, 1'b0);
    `CHK("midrst_aw_valid", mst_req.aw_valid, 1'b0);
    tick();
    aw1 = aw_n;
    rst_n = 1'b1;
    tick();
    `CHK("restart_busy", busy, 1'b1);
    wait_done("init3_done");
    `CHK("restart_addr0", aw_log_addr[aw1[7:0]], BASE);
    `CHK("restart_aw_count", aw_n - aw1, 33);
    chk_mem("init3_mem", 64'hA5A5_0000_FFFF_0003);

`ifdef CHIMERA_MEMISL_INIT_ERRCNT_EN
    inj_en = 1'b1;
    init = 1'b1;
    tick();
    init = 1'b0;
    wait_done("errcnt_done");
    `CHK("errcnt_value", err_cnt, 16'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
